cd_cfg_ctrl: RTL

- Configuration sequencer and arbiter for the clock-divider (CD) config bus (c_addr/c_data/c_valid/c_ready).
- After reset it plays a fixed boot table that loads default divider values for the VGA, UART, LM and DB clock outputs.
- After boot it shares the single CD config port between two requesters (req0: UART command path, req1: debug/switch path) using round-robin arbitration.
- It forwards one write at a time with a valid/ready handshake and rejects out-of-range addresses.

---
 rtl/cd_cfg_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cd_cfg_ctrl.sv
// Clock-divider config sequencer/arbiter: plays a boot table of default dividers,
// then round-robins two requesters onto the single CD config write port.
// Optional read-back shadow of accepted values when CD_CFG_SHADOW_EN is defined.
module cd_cfg_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 14,
  parameter int N_TGT    = 4,
  parameter int DEF_VGA  = 2,
  parameter int DEF_UART = 434,
  parameter int DEF_LM   = 5000,
  parameter int DEF_DB   = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data,
  output logic              c_valid,
  input  logic              c_ready,
  output logic              boot_done,
  output logic              err,
  output logic              busy
`ifdef CD_CFG_SHADOW_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   N_TGT_W  = (ADDR_W+1)'(N_TGT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TGT - 1);

  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    is_legal = ({1'b0, a} < N_TGT_W);
  endfunction

  function automatic logic [DATA_W-1:0] def_val(input logic [ADDR_W-1:0] i);
    case (i)
      ADDR_W'(0): def_val = DATA_W'(DEF_VGA);
      ADDR_W'(1): def_val = DATA_W'(DEF_UART);
      ADDR_W'(2): def_val = DATA_W'(DEF_LM);
      ADDR_W'(3): def_val = DATA_W'(DEF_DB);
      default:    def_val = {DATA_W{1'b0}};
    endcase
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   idx_r, idx_s;
  logic                c_valid_r, c_valid_s;
  logic [ADDR_W-1:0]   c_addr_r, c_addr_s;
  logic [DATA_W-1:0]   c_data_r, c_data_s;
  logic                boot_done_r, boot_done_s;
  logic                err_r, err_s;
  logic                last_grant_r, last_grant_s;
  logic                gnt0_s, gnt1_s;
  logic                accept_s;

  // Next-state, grant and output-register logic for the BOOT/IDLE/SEND sequencer
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    c_valid_s    = c_valid_r;
    c_addr_s     = c_addr_r;
    c_data_s     = c_data_r;
    boot_done_s  = boot_done_r;
    err_s        = 1'b0;
    last_grant_s = last_grant_r;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    accept_s     = c_valid_r && c_ready;

    case (state_r)
      ST_BOOT: begin
        if (accept_s) begin
          idx_s = idx_r + ADDR_W'(1);
          if (idx_r == LAST_IDX) begin
            state_s     = ST_IDLE;
            c_valid_s   = 1'b0;
            boot_done_s = 1'b1;
          end else begin
            c_valid_s = 1'b1;
            c_addr_s  = idx_r + ADDR_W'(1);
            c_data_s  = def_val(idx_r + ADDR_W'(1));
          end
        end else begin
          c_valid_s = 1'b1;
          c_addr_s  = idx_r;
          c_data_s  = def_val(idx_r);
        end
      end

      ST_IDLE: begin
        c_valid_s = 1'b0;
        // On a tie the requester that did not win last time gets the port
        gnt0_s = r0_valid && (!r1_valid || last_grant_r);
        gnt1_s = r1_valid && !gnt0_s;
        if (gnt0_s || gnt1_s) begin
          c_addr_s     = gnt1_s ? r1_addr : r0_addr;
          c_data_s     = gnt1_s ? r1_data : r0_data;
          last_grant_s = gnt1_s;
          if (is_legal(c_addr_s)) begin
            state_s   = ST_SEND;
            c_valid_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (accept_s) begin
          c_valid_s = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          c_valid_s = 1'b1;
        end
      end

      default: begin
        state_s   = ST_BOOT;
        idx_s     = {ADDR_W{1'b0}};
        c_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_BOOT;
      idx_r        <= {ADDR_W{1'b0}};
      c_valid_r    <= 1'b0;
      c_addr_r     <= {ADDR_W{1'b0}};
      c_data_r     <= {DATA_W{1'b0}};
      boot_done_r  <= 1'b0;
      err_r        <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      c_valid_r    <= c_valid_s;
      c_addr_r     <= c_addr_s;
      c_data_r     <= c_data_s;
      boot_done_r  <= boot_done_s;
      err_r        <= err_s;
      last_grant_r <= last_grant_s;
    end
  end

  assign r0_ready  = gnt0_s;
  assign r1_ready  = gnt1_s;
  assign c_valid   = c_valid_r;
  assign c_addr    = c_addr_r;
  assign c_data    = c_data_r;
  assign boot_done = boot_done_r;
  assign err       = err_r;
  assign busy      = (state_r == ST_BOOT) || (state_r == ST_SEND);

`ifdef CD_CFG_SHADOW_EN
  localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

  logic [DATA_W-1:0] shadow_r [N_TGT];

  // Shadow copy of every value the CD accepts, boot writes included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TGT; i++) begin
        shadow_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept_s && is_legal(c_addr_r)) begin
      shadow_r[c_addr_r[IDX_W-1:0]] <= c_data_r;
    end
  end

  // Combinational read-back, zero for addresses outside the target range
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (is_legal(rd_addr)) begin
      rd_data = shadow_r[rd_addr[IDX_W-1:0]];
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
  end
`else
  // No read-back shadow in this build
`endif

endmodule
